// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the decode/operand stage: widths, ALU NOP encodings,
// the all-zero data word and the stall FSM state type.
package id_operand_stage_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int NUM_FWD_DEF = 3;

  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;
  localparam int STALL_CNT_W = 16;

  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP = 3'b000;
  localparam logic [31:0]         ZERO_WORD   = 32'h0000_0000;

  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// Operand resolution for one read port: immediate, hardwired zero register,
// prioritised forwarding (index 0 youngest) or register-file data. Also flags
// when the winning forwarding source is a load whose data is not ready yet.
module fwd_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input  logic                      read_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         reg_data,
  input  logic [DATA_W-1:0]         imm,
  input  logic [NUM_FWD-1:0]        fwd_wreg,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic [DATA_W-1:0]         data,
  output logic                      load_hit
);

  // Select the operand source; scanning from the oldest source down lets the
  // youngest matching source overwrite and therefore win.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    data     = reg_data;
    load_hit = 1'b0;
    if (!read_en) begin
      data = imm;
    end else if (addr == '0) begin
      data = DATA_W'(ZERO_WORD);
    end else begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_wreg[k] && (fwd_wd[k*ADDR_W +: ADDR_W] == addr)) begin
          data     = fwd_wdata[k*DATA_W +: DATA_W];
          load_hit = fwd_is_load[k];
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage: resolves both operands with forwarding,
// detects load-use hazards, and holds the result in a valid/ready output
// register. A small RUN/STALL FSM tracks stalls; a saturating counter
// records stall cycles.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_FWD = NUM_FWD_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      reg1_read_i,
  input  logic                      reg2_read_i,
  input  logic [ADDR_W-1:0]         reg1_addr_i,
  input  logic [ADDR_W-1:0]         reg2_addr_i,
  input  logic [DATA_W-1:0]         imm_i,
  input  logic [ADDR_W-1:0]         wd_i,
  input  logic                      wreg_i,
  input  logic [ALUOP_W-1:0]        aluop_i,
  input  logic [ALUSEL_W-1:0]       alusel_i,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_is_load_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [DATA_W-1:0]         reg1_o,
  output logic [DATA_W-1:0]         reg2_o,
  output logic [ADDR_W-1:0]         wd_o,
  output logic                      wreg_o,
  output logic [ALUOP_W-1:0]        aluop_o,
  output logic [ALUSEL_W-1:0]       alusel_o,
  output logic                      stall_req_o,
  output logic [STALL_CNT_W-1:0]    stall_cnt_o
);

  logic [DATA_W-1:0] reg1_res;
  logic [DATA_W-1:0] reg2_res;
  logic              reg1_load_hit;
  logic              reg2_load_hit;
  logic              hazard;
  logic              capture;
  state_t            state;

  fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_FWD(NUM_FWD)
  ) u_fwd_mux_reg1 (
    .read_en    (reg1_read_i),
    .addr       (reg1_addr_i),
    .reg_data   (reg1_data_i),
    .imm        (imm_i),
    .fwd_wreg   (fwd_wreg_i),
    .fwd_wd     (fwd_wd_i),
    .fwd_wdata  (fwd_wdata_i),
    .fwd_is_load(fwd_is_load_i),
    .data       (reg1_res),
    .load_hit   (reg1_load_hit)
  );

  fwd_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_FWD(NUM_FWD)
  ) u_fwd_mux_reg2 (
    .read_en    (reg2_read_i),
    .addr       (reg2_addr_i),
    .reg_data   (reg2_data_i),
    .imm        (imm_i),
    .fwd_wreg   (fwd_wreg_i),
    .fwd_wd     (fwd_wd_i),
    .fwd_wdata  (fwd_wdata_i),
    .fwd_is_load(fwd_is_load_i),
    .data       (reg2_res),
    .load_hit   (reg2_load_hit)
  );

  // A load still in flight feeding either operand blocks the instruction.
  assign hazard      = valid_i & (reg1_load_hit | reg2_load_hit);
  // Reset silences both pipeline-control outputs; flush overrides a hazard.
  assign stall_req_o = ~rst & hazard & ~flush_i;
  assign ready_o     = ~rst & (flush_i | (~hazard & (~valid_o | ready_i)));
  assign capture     = valid_i & ready_o & ~flush_i;

  // Stall tracking FSM: enter STALL on an unflushed hazard, leave once clear.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
    end else if (flush_i) begin
      state <= S_RUN;
    end else begin
      case (state)
        S_RUN:   if (hazard)  state <= S_STALL;
        S_STALL: if (!hazard) state <= S_RUN;
        default: state <= S_RUN;
      endcase
    end
  end

  // Output register: flush drops the entry, capture loads, a consumed entry
  // with nothing new becomes a bubble, back-pressure holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o  <= 1'b0;
      reg1_o   <= DATA_W'(ZERO_WORD);
      reg2_o   <= DATA_W'(ZERO_WORD);
      wd_o     <= '0;
      wreg_o   <= 1'b0;
      aluop_o  <= EXE_NOP_OP;
      alusel_o <= EXE_RES_NOP;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
    end else if (capture) begin
      valid_o  <= 1'b1;
      reg1_o   <= reg1_res;
      reg2_o   <= reg2_res;
      wd_o     <= wd_i;
      wreg_o   <= wreg_i;
      aluop_o  <= aluop_i;
      alusel_o <= alusel_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      wreg_o  <= 1'b0;
    end
  end

  // Saturating count of cycles spent requesting a load-use stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (stall_req_o && (stall_cnt_o != STALL_CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_FWD = 3;

  logic                      clk;
  logic                      rst;
  logic                      valid_i;
  logic                      ready_o;
  logic                      reg1_read_i;
  logic                      reg2_read_i;
  logic [ADDR_W-1:0]         reg1_addr_i;
  logic [ADDR_W-1:0]         reg2_addr_i;
  logic [DATA_W-1:0]         imm_i;
  logic [ADDR_W-1:0]         wd_i;
  logic                      wreg_i;
  logic [7:0]                aluop_i;
  logic [2:0]                alusel_i;
  logic [DATA_W-1:0]         reg1_data_i;
  logic [DATA_W-1:0]         reg2_data_i;
  logic [NUM_FWD-1:0]        fwd_wreg_i;
  logic [NUM_FWD*ADDR_W-1:0] fwd_wd_i;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i;
  logic [NUM_FWD-1:0]        fwd_is_load_i;
  logic                      flush_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [DATA_W-1:0]         reg1_o;
  logic [DATA_W-1:0]         reg2_o;
  logic [ADDR_W-1:0]         wd_o;
  logic                      wreg_o;
  logic [7:0]                aluop_o;
  logic [2:0]                alusel_o;
  logic                      stall_req_o;
  logic [15:0]               stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the registered outputs.
  logic              m_valid;
  logic [DATA_W-1:0] m_reg1;
  logic [DATA_W-1:0] m_reg2;
  logic [ADDR_W-1:0] m_wd;
  logic              m_wreg;
  logic [7:0]        m_aluop;
  logic [2:0]        m_alusel;
  logic [15:0]       m_cnt;

  id_operand_stage #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_FWD(NUM_FWD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .reg1_read_i  (reg1_read_i),
    .reg2_read_i  (reg2_read_i),
    .reg1_addr_i  (reg1_addr_i),
    .reg2_addr_i  (reg2_addr_i),
    .imm_i        (imm_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .aluop_i      (aluop_i),
    .alusel_i     (alusel_i),
    .reg1_data_i  (reg1_data_i),
    .reg2_data_i  (reg2_data_i),
    .fwd_wreg_i   (fwd_wreg_i),
    .fwd_wd_i     (fwd_wd_i),
    .fwd_wdata_i  (fwd_wdata_i),
    .fwd_is_load_i(fwd_is_load_i),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .reg1_o       (reg1_o),
    .reg2_o       (reg2_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .aluop_o      (aluop_o),
    .alusel_o     (alusel_o),
    .stall_req_o  (stall_req_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference operand resolution: first matching source in priority order.
  task automatic resolve(input logic rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] rdata,
                         output logic [DATA_W-1:0] d, output logic ld);
    ld = 1'b0;
    if (!rd) begin
      d = imm_i;
    end else if (a == 0) begin
      d = 0;
    end else begin
      d = rdata;
      for (int k = 0; k < NUM_FWD; k++) begin
        if (fwd_wreg_i[k] && fwd_wd_i[k*ADDR_W +: ADDR_W] == a) begin
          d  = fwd_wdata_i[k*DATA_W +: DATA_W];
          ld = fwd_is_load_i[k];
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_reg1   = '0;
    m_reg2   = '0;
    m_wd     = '0;
    m_wreg   = 1'b0;
    m_aluop  = EXE_NOP_OP;
    m_alusel = EXE_RES_NOP;
    m_cnt    = '0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model,
  // then check every registered output just after the edge.
  task automatic tick();
    logic [DATA_W-1:0] d1, d2;
    logic l1, l2, hz, exp_rdy, exp_stall, cap;
    resolve(reg1_read_i, reg1_addr_i, reg1_data_i, d1, l1);
    resolve(reg2_read_i, reg2_addr_i, reg2_data_i, d2, l2);
    hz        = valid_i && (l1 || l2);
    exp_stall = !rst && hz && !flush_i;
    exp_rdy   = !rst && (flush_i || (!hz && (!m_valid || ready_i)));
    cap       = valid_i && exp_rdy && !flush_i;
    #3;
    check("ready_o", 32'(ready_o), 32'(exp_rdy));
    check("stall_req_o", 32'(stall_req_o), 32'(exp_stall));
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (exp_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (flush_i) begin
        m_valid = 1'b0;
        m_wreg  = 1'b0;
      end else if (cap) begin
        m_valid  = 1'b1;
        m_reg1   = d1;
        m_reg2   = d2;
        m_wd     = wd_i;
        m_wreg   = wreg_i;
        m_aluop  = aluop_i;
        m_alusel = alusel_i;
      end else if (ready_i) begin
        m_valid = 1'b0;
        m_wreg  = 1'b0;
      end
    end
    check("valid_o", 32'(valid_o), 32'(m_valid));
    check("reg1_o", reg1_o, m_reg1);
    check("reg2_o", reg2_o, m_reg2);
    check("wd_o", 32'(wd_o), 32'(m_wd));
    check("wreg_o", 32'(wreg_o), 32'(m_wreg));
    check("aluop_o", 32'(aluop_o), 32'(m_aluop));
    check("alusel_o", 32'(alusel_o), 32'(m_alusel));
    check("stall_cnt_o", 32'(stall_cnt_o), 32'(m_cnt));
  endtask

  task automatic clear_inputs();
    rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    reg1_read_i = 1'b0; reg2_read_i = 1'b0;
    reg1_addr_i = '0; reg2_addr_i = '0; imm_i = '0;
    wd_i = '0; wreg_i = 1'b0; aluop_i = '0; alusel_i = '0;
    reg1_data_i = '0; reg2_data_i = '0;
    fwd_wreg_i = '0; fwd_wd_i = '0; fwd_wdata_i = '0; fwd_is_load_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic random_inputs();
    rst         = ($urandom_range(0, 49) == 0);
    flush_i     = ($urandom_range(0, 9) == 0);
    valid_i     = ($urandom_range(0, 3) != 0);
    ready_i     = ($urandom_range(0, 3) != 0);
    reg1_read_i = 1'($urandom);
    reg2_read_i = 1'($urandom);
    reg1_addr_i = ADDR_W'($urandom_range(0, 7));
    reg2_addr_i = ADDR_W'($urandom_range(0, 7));
    imm_i       = $urandom;
    wd_i        = ADDR_W'($urandom);
    wreg_i      = 1'($urandom);
    aluop_i     = 8'($urandom);
    alusel_i    = 3'($urandom);
    reg1_data_i = $urandom;
    reg2_data_i = $urandom;
    fwd_wreg_i  = NUM_FWD'($urandom);
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd_wd_i[k*ADDR_W +: ADDR_W]    = ADDR_W'($urandom_range(0, 7));
      fwd_wdata_i[k*DATA_W +: DATA_W] = $urandom;
      fwd_is_load_i[k]                = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Load to r3 in forwarding slot 0 while the instruction reads r3.
  task automatic setup_load_hazard();
    clear_inputs();
    valid_i     = 1'b1;
    reg1_read_i = 1'b1;
    reg1_addr_i = 5'd3;
    reg1_data_i = 32'h0000_0999;
    fwd_wreg_i  = 3'b001;
    fwd_wd_i[0 +: ADDR_W] = 5'd3;
    fwd_wdata_i[0 +: DATA_W] = 32'h0000_0055;
    fwd_is_load_i = 3'b001;
    wreg_i = 1'b1; wd_i = 5'd7; aluop_i = 8'h25; alusel_i = 3'b001;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    do_reset();
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_aluop", 32'(aluop_o), 32'(EXE_NOP_OP));

    // Two sources write r5; the youngest must win.
    clear_inputs();
    valid_i = 1'b1; reg1_read_i = 1'b1; reg1_addr_i = 5'd5;
    reg1_data_i = 32'hDEAD_BEEF;
    fwd_wreg_i = 3'b011;
    fwd_wd_i[0 +: ADDR_W] = 5'd5; fwd_wd_i[ADDR_W +: ADDR_W] = 5'd5;
    fwd_wdata_i[0 +: DATA_W] = 32'h11; fwd_wdata_i[DATA_W +: DATA_W] = 32'h22;
    wreg_i = 1'b1; wd_i = 5'd9; aluop_i = 8'h21; alusel_i = 3'b100;
    tick();
    check("prio_reg1", reg1_o, 32'h11);

    // Register zero reads zero even when forwarded.
    clear_inputs();
    valid_i = 1'b1; reg2_read_i = 1'b1; reg2_addr_i = 5'd0;
    reg2_data_i = 32'h1234; fwd_wreg_i = 3'b001;
    fwd_wdata_i[0 +: DATA_W] = 32'hFFFF_FFFF;
    tick();
    check("r0_reg2", reg2_o, 32'h0);

    // Load-use stall, then release with the load data.
    do_reset();
    setup_load_hazard();
    tick();
    check("stall_valid", 32'(valid_o), 32'd0);
    fwd_is_load_i = 3'b000;
    fwd_wdata_i[0 +: DATA_W] = 32'h77;
    tick();
    check("release_reg1", reg1_o, 32'h77);
    check("release_valid", 32'(valid_o), 32'd1);
    check("release_cnt", 32'(stall_cnt_o), 32'd1);

    // Back-pressure holds outputs.
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      rst = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
      tick();
      check("hold_reg1", reg1_o, 32'h77);
      check("hold_valid", 32'(valid_o), 32'd1);
    end

    // Flush during a stall.
    do_reset();
    setup_load_hazard();
    tick();
    flush_i = 1'b1;
    tick();
    check("flush_valid", 32'(valid_o), 32'd0);
    clear_inputs();
    tick();

    // Reset in the middle of a stall with a valid entry held.
    do_reset();
    clear_inputs();
    valid_i = 1'b1; reg1_read_i = 1'b1; reg1_addr_i = 5'd4;
    reg1_data_i = 32'hABCD; wreg_i = 1'b1; aluop_i = 8'h2A;
    tick();
    setup_load_hazard();
    ready_i = 1'b0;
    tick();
    check("mid_stall_cnt", 32'(stall_cnt_o), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_cnt", 32'(stall_cnt_o), 32'd0);
    check("rst_reg1", reg1_o, 32'h0);
    check("rst_alusel", 32'(alusel_o), 32'(EXE_RES_NOP));
    rst = 1'b0;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, operand/data width; ADDR_W, default 5, register address width; NUM_FWD, default 3, forwarding sources, index 0 = youngest, highest priority.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 valid_i  in  1, ready_o  out  1: decoded-instruction handshake from decode.
REQ-005 reg1_read_i, reg2_read_i  in  1 each; reg1_addr_i, reg2_addr_i  in  ADDR_W each; imm_i  in  DATA_W; wd_i  in  ADDR_W; wreg_i  in  1; aluop_i  in  8; alusel_i  in  3: decoded fields.
REQ-006 reg1_data_i, reg2_data_i  in  DATA_W each: register-file read data for reg1_addr_i, reg2_addr_i.
REQ-007 fwd_wreg_i  in  NUM_FWD; fwd_wd_i  in  NUM_FWD*ADDR_W; fwd_wdata_i  in  NUM_FWD*DATA_W; fwd_is_load_i  in  NUM_FWD (write data not yet valid).
REQ-008 flush_i  in  1: discard held and incoming instruction.
REQ-009 valid_o  out  1, ready_i  in  1: handshake to execute.
REQ-010 reg1_o, reg2_o  out  DATA_W; wd_o  out  ADDR_W; wreg_o  out  1; aluop_o  out  8; alusel_o  out  3: registered operands/control.
REQ-011 stall_req_o  out  1: load-use stall request to pipeline control; stall_cnt_o  out  16: stall-cycle counter.

Function
REQ-012 Operand n SHALL resolve: if regn_read_i=0 -> imm_i; else if regn_addr_i=0 -> 0; else lowest index k with fwd_wreg_i[k]=1 and fwd_wd_i[k]=regn_addr_i -> fwd_wdata_i[k]; else regn_data_i.
REQ-013 Load hazard SHALL be asserted when valid_i=1 and, for either read operand with nonzero address, the winning source k of REQ-012 has fwd_is_load_i[k]=1.
REQ-014 FSM SHALL have states RUN and STALL; RUN->STALL on hazard while not flushed; STALL->RUN in the first cycle hazard is clear, capturing that cycle; any state->RUN on flush_i.
REQ-015 stall_req_o SHALL equal hazard & ~flush_i, combinationally, in both states.
REQ-016 ready_o SHALL equal flush_i | (~hazard & (~valid_o | ready_i)).
REQ-017 Capture (valid_i & ready_o & ~flush_i) SHALL load all output fields and set valid_o=1 next cycle; latency exactly 1 cycle.
REQ-018 If no capture and ready_i=1, valid_o SHALL clear (bubble); if ready_i=0, outputs SHALL hold unchanged.
REQ-019 Hazard with ready_i=1 SHALL produce valid_o=0 next cycle (bubble into execute).
REQ-020 flush_i SHALL force valid_o=0 next cycle regardless of hazard, ready_i or valid_i; flush beats hazard and capture.
REQ-021 stall_cnt_o SHALL increment by 1 each cycle stall_req_o=1, saturating at 16'hFFFF.
REQ-022 When valid_o=0, wreg_o SHALL be 0 so no write is issued downstream.

Reset
REQ-023 On rst=1 at a clock edge: state=RUN, valid_o=0, reg1_o=reg2_o=0, wd_o=0, wreg_o=0, aluop_o=NOP op, alusel_o=NOP result, stall_cnt_o=0.
REQ-024 rst SHALL dominate flush_i, capture and hazard; a stall in progress is abandoned.
REQ-025 While rst=1, ready_o and stall_req_o SHALL be 0.

Structure
REQ-026 Widths, ALU op/sel encodings (NOP op, NOP result) and ZeroWord SHALL come from the shared define file; no local copies.
REQ-027 Operand resolution SHALL be one sub-module, fwd_mux, instantiated twice, parametrised by DATA_W, ADDR_W, NUM_FWD, returning data and a load-hit flag.
REQ-028 FSM, output register and counter SHALL reside in id_operand_stage.

Verification
REQ-029 Source 0 and 1 both write r5 (0x11, 0x22), reg1_addr=5 -> reg1_o=0x11 one cycle after capture.
REQ-030 reg2_addr=0, fwd 0 writes r0 with 0xFFFF_FFFF -> reg2_o=0.
REQ-031 Source 0 is load to r3, instruction reads r3 -> stall_req_o=1, ready_o=0, valid_o=0 next cycle; fwd_is_load_i cleared, data 0x77 -> capture, reg1_o=0x77, stall_cnt_o=1.
REQ-032 valid_o=1, ready_i=0 for 3 cycles -> all outputs stable; ready_o=0.
REQ-033 flush_i during STALL -> state RUN, valid_o=0 next cycle, stall_req_o=0.
REQ-034 rst asserted mid-stall with valid_o=1 -> next cycle all outputs at REQ-023 values, stall_cnt_o=0.
